// File: rtl/gravity_pkg.sv
// Shared definitions for the gravity game: player count, state encoding,
// counter width selection and a popcount helper also used by the renderer.
// Optional feature macro: SCOREBOARD_BCD_EN (4-digit packed BCD counters).
package gravity_pkg;

    localparam int NUM_PLAYERS = 4;
    localparam int PID_W       = 2;
    localparam int SCORE_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_OVER = 2'b10
    } state_t;

`ifdef SCOREBOARD_BCD_EN
    localparam bit BCD_EN = 1'b1;
`else
    localparam bit BCD_EN = 1'b0;
`endif

    // BCD counters are always four digits wide regardless of the requested width
    function automatic int cnt_w(input int w);
        return BCD_EN ? 16 : w;
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/game_scoreboard_score_counter.sv
// Saturating frame counter with synchronous clear.
// SCOREBOARD_BCD_EN defined: 4-digit packed BCD, saturates at 16'h9999 (W must be 16).
// Otherwise: plain binary, saturates at all-ones.
module score_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;
    logic [W-1:0] w_next;
    logic         w_sat;

`ifdef SCOREBOARD_BCD_EN
    logic w_carry;

    // Ripple a +1 through the four BCD digits, each rolling 9 -> 0 with carry
    always_comb begin
        w_next  = r_q;
        w_carry = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (w_carry) begin
                if (r_q[4*i +: 4] == 4'd9) begin
                    w_next[4*i +: 4] = 4'd0;
                end else begin
                    w_next[4*i +: 4] = r_q[4*i +: 4] + 4'd1;
                    w_carry          = 1'b0;
                end
            end
        end
        w_sat = (r_q == 16'h9999);
    end
`else
    // Binary increment; saturation at all-ones
    always_comb begin
        w_next = r_q + W'(1);
        w_sat  = &r_q;
    end
`endif

    // Counter register: clear wins over increment, hold once saturated
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && !w_sat) begin
            r_q <= w_next;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/game_scoreboard.sv
// Game-level scoreboard: IDLE/RUN/OVER FSM, roster latch, per-player survival
// scores, elapsed frame count, winner/tie detection and playfield freeze.
// Optional feature macro: SCOREBOARD_BCD_EN (BCD counters, width fixed at 16).
module game_scoreboard
    import gravity_pkg::*;
#(
    parameter int SCORE_W = SCORE_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        tick,
    input  logic                        enable_board,
    input  logic [3:0]                  in_game,
    input  logic [3:0]                  dead,
    input  logic                        restart,
    output logic [1:0]                  state_o,
    output logic                        board_freeze,
    output logic [PID_W-1:0]            winner,
    output logic                        winner_valid,
    output logic                        tie,
    output logic [cnt_w(SCORE_W)-1:0]   score_p1,
    output logic [cnt_w(SCORE_W)-1:0]   score_p2,
    output logic [cnt_w(SCORE_W)-1:0]   score_p3,
    output logic [cnt_w(SCORE_W)-1:0]   score_p4,
    output logic [cnt_w(SCORE_W)-1:0]   elapsed
);

    localparam int CW = cnt_w(SCORE_W);

    state_t                 r_state;
    logic [3:0]             r_roster;
    logic [PID_W-1:0]       r_winner;
    logic                   r_winner_valid;
    logic                   r_tie;
    logic                   r_freeze;

    logic [3:0]             w_alive;
    logic [2:0]             w_alive_cnt;
    logic                   w_multi;
    logic                   w_end;
    logic                   w_start;
    logic                   w_run_tick;
    logic [PID_W-1:0]       w_alive_idx;
    logic [CW-1:0]          w_score [NUM_PLAYERS];

    assign w_alive     = r_roster & ~dead;
    assign w_alive_cnt = popcount4(w_alive);
    assign w_multi     = popcount4(r_roster) >= 3'd2;
    assign w_end       = w_multi ? (w_alive_cnt <= 3'd1) : (w_alive == 4'b0000);
    assign w_start     = (r_state == ST_IDLE) && enable_board && (|in_game);
    assign w_run_tick  = (r_state == ST_RUN) && tick;

    // Index of the (last) alive player; only meaningful when exactly one remains
    always_comb begin
        w_alive_idx = '0;
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            if (w_alive[i]) begin
                w_alive_idx = PID_W'(i);
            end
        end
    end

    // Game FSM with registered result and freeze outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_roster       <= '0;
            r_winner       <= '0;
            r_winner_valid <= 1'b0;
            r_tie          <= 1'b0;
            r_freeze       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state        <= ST_RUN;
                        r_roster       <= in_game;
                        r_winner_valid <= 1'b0;
                        r_tie          <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Board disable aborts the game without a result
                    if (!enable_board) begin
                        r_state        <= ST_IDLE;
                        r_winner_valid <= 1'b0;
                        r_tie          <= 1'b0;
                    end else if (w_end) begin
                        r_state  <= ST_OVER;
                        r_freeze <= 1'b1;
                        if (w_alive_cnt == 3'd1) begin
                            r_winner       <= w_alive_idx;
                            r_winner_valid <= 1'b1;
                            r_tie          <= 1'b0;
                        end else begin
                            r_winner       <= '0;
                            r_winner_valid <= 1'b0;
                            r_tie          <= w_multi;
                        end
                    end
                end
                ST_OVER: begin
                    if (restart) begin
                        r_state  <= ST_IDLE;
                        r_freeze <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_freeze <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_score
        score_counter #(.W(CW)) u_score (
            .clk   (clk),
            .reset (reset),
            .clr   (w_start),
            .inc   (w_run_tick && w_alive[g]),
            .q     (w_score[g])
        );
    end

    score_counter #(.W(CW)) u_elapsed (
        .clk   (clk),
        .reset (reset),
        .clr   (w_start),
        .inc   (w_run_tick),
        .q     (elapsed)
    );

    assign state_o      = r_state;
    assign board_freeze = r_freeze;
    assign winner       = r_winner;
    assign winner_valid = r_winner_valid;
    assign tie          = r_tie;
    assign score_p1     = w_score[0];
    assign score_p2     = w_score[1];
    assign score_p3     = w_score[2];
    assign score_p4     = w_score[3];

endmodule

// File: tb/tb_game_scoreboard.sv
// Self-checking bench for game_scoreboard. A second, narrow instance exercises
// counter saturation (8-bit binary, or 16-bit BCD when SCOREBOARD_BCD_EN is set).
module tb_game_scoreboard;

`ifdef SCOREBOARD_BCD_EN
    localparam int SAT_W   = 16;
    localparam int SAT_MAX = 9999;
`else
    localparam int SAT_W   = 8;
    localparam int SAT_MAX = 255;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, tick, enable_board, restart;
    logic [3:0]  in_game, dead;
    logic [1:0]  state_o, winner;
    logic        board_freeze, winner_valid, tie;
    logic [15:0] score_p1, score_p2, score_p3, score_p4, elapsed;

    logic              s_tick, s_en, s_restart;
    logic [3:0]        s_in_game, s_dead;
    logic [1:0]        s_state, s_winner;
    logic              s_freeze, s_wv, s_tie;
    logic [SAT_W-1:0]  s_p1, s_p2, s_p3, s_p4, s_el;

    game_scoreboard u_dut (
        .clk(clk), .reset(reset), .tick(tick), .enable_board(enable_board),
        .in_game(in_game), .dead(dead), .restart(restart),
        .state_o(state_o), .board_freeze(board_freeze), .winner(winner),
        .winner_valid(winner_valid), .tie(tie),
        .score_p1(score_p1), .score_p2(score_p2), .score_p3(score_p3),
        .score_p4(score_p4), .elapsed(elapsed)
    );

    game_scoreboard #(.SCORE_W(8)) u_sat (
        .clk(clk), .reset(reset), .tick(s_tick), .enable_board(s_en),
        .in_game(s_in_game), .dead(s_dead), .restart(s_restart),
        .state_o(s_state), .board_freeze(s_freeze), .winner(s_winner),
        .winner_valid(s_wv), .tie(s_tie),
        .score_p1(s_p1), .score_p2(s_p2), .score_p3(s_p3),
        .score_p4(s_p4), .elapsed(s_el)
    );

    typedef enum int {
        S_STATE, S_FREEZE, S_WIN, S_WV, S_TIE,
        S_P1, S_P2, S_P3, S_P4, S_EL,
        S_SP1, S_SEL, S_SMISC, S_SOTH
    } sel_e;

    typedef struct {
        string       tag;
        sel_e        sel;
        logic [31:0] val;
    } exp_t;

    exp_t        q_exp[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    function automatic logic [31:0] observe(sel_e s);
        case (s)
            S_STATE:  return {30'd0, state_o};
            S_FREEZE: return {31'd0, board_freeze};
            S_WIN:    return {30'd0, winner};
            S_WV:     return {31'd0, winner_valid};
            S_TIE:    return {31'd0, tie};
            S_P1:     return {16'd0, score_p1};
            S_P2:     return {16'd0, score_p2};
            S_P3:     return {16'd0, score_p3};
            S_P4:     return {16'd0, score_p4};
            S_EL:     return {16'd0, elapsed};
            S_SP1:    return 32'(s_p1);
            S_SEL:    return 32'(s_el);
            S_SMISC:  return {25'd0, s_state, s_freeze, s_winner, s_wv, s_tie};
            S_SOTH:   return 32'(s_p2 | s_p3 | s_p4);
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Expected saturating-counter value after n ticks in this build
    function automatic logic [31:0] sat_exp(int n);
        int m;
        m = (n > SAT_MAX) ? SAT_MAX : n;
`ifdef SCOREBOARD_BCD_EN
        return 32'(((m / 1000) << 12) | (((m / 100) % 10) << 8) | (((m / 10) % 10) << 4) | (m % 10));
`else
        return 32'(m);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic push(input string tag, input sel_e s, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = s;
        e.val = v;
        q_exp.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            chk(e.tag, observe(e.sel), e.val);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_cyc();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic end_game();
        restart      = 1'b1;
        enable_board = 1'b0;
        dead         = 4'b0000;
        cyc();
        restart = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; tick = 1'b0; enable_board = 1'b0; restart = 1'b0;
        in_game = 4'b0000; dead = 4'b0000;
        s_tick = 1'b0; s_en = 1'b0; s_restart = 1'b0; s_in_game = 4'b0000; s_dead = 4'b0000;
        cyc(); cyc();

        // Reset state
        push("rst_state", S_STATE, 0);  push("rst_freeze", S_FREEZE, 0);
        push("rst_win", S_WIN, 0);      push("rst_wv", S_WV, 0);
        push("rst_tie", S_TIE, 0);      push("rst_p1", S_P1, 0);
        push("rst_p4", S_P4, 0);        push("rst_el", S_EL, 0);
        drain();
        reset = 1'b1;
        cyc();

        // Test 1: roster 1011, p2 dies after tick 30, p1 after tick 60
        in_game = 4'b1011; enable_board = 1'b1;
        cyc();
        push("t1_run", S_STATE, 1);
        drain();
        for (int t = 1; t <= 100; t++) begin
            tick_cyc();
            if (t == 30) dead[1] = 1'b1;
            if (t == 60) dead[0] = 1'b1;
            cyc();
            if (t == 30) begin
                push("t1_still_run", S_STATE, 1);
                drain();
            end
            if (t == 60) begin
                push("t1_over_lat", S_STATE, 2);
                push("t1_freeze_lat", S_FREEZE, 1);
                drain();
            end
        end
        push("t1_p1", S_P1, 60); push("t1_p2", S_P2, 30);
        push("t1_p3", S_P3, 0);  push("t1_p4", S_P4, 60);
        push("t1_el", S_EL, 60); push("t1_win", S_WIN, 3);
        push("t1_wv", S_WV, 1);  push("t1_tie", S_TIE, 0);
        push("t1_freeze", S_FREEZE, 1);
        drain();

        // Test 6a: restart from OVER returns to IDLE with results still visible
        end_game();
        push("t6_idle", S_STATE, 0); push("t6_unfreeze", S_FREEZE, 0);
        push("t6_p1_hold", S_P1, 60); push("t6_wv_hold", S_WV, 1);
        push("t6_win_hold", S_WIN, 3);
        drain();

        // Test 2: both players die together with a tick -> tie
        in_game = 4'b0011; enable_board = 1'b1;
        cyc();
        push("t2_start_wv", S_WV, 0); push("t2_start_p1", S_P1, 0);
        push("t2_start_el", S_EL, 0);
        drain();
        repeat (11) tick_cyc();
        dead = 4'b0011; tick = 1'b1;
        cyc();
        tick = 1'b0;
        push("t2_state", S_STATE, 2); push("t2_tie", S_TIE, 1);
        push("t2_wv", S_WV, 0);       push("t2_p1", S_P1, 11);
        push("t2_p2", S_P2, 11);      push("t2_el", S_EL, 12);
        drain();
        end_game();

        // Coincident tick is credited to the survivor only
        in_game = 4'b0111; enable_board = 1'b1;
        cyc();
        repeat (5) tick_cyc();
        dead = 4'b0011; tick = 1'b1;
        cyc();
        tick = 1'b0;
        push("t2b_p3", S_P3, 6); push("t2b_p1", S_P1, 5);
        push("t2b_win", S_WIN, 2); push("t2b_wv", S_WV, 1);
        push("t2b_tie", S_TIE, 0);
        drain();
        end_game();

        // Test 6b: roster locked during RUN; restart in RUN ignored
        in_game = 4'b0011; enable_board = 1'b1;
        cyc();
        in_game = 4'b1111; restart = 1'b1;
        cyc();
        restart = 1'b0;
        push("t6_rst_ign", S_STATE, 1);
        drain();
        repeat (3) tick_cyc();
        dead = 4'b0001;
        cyc();
        push("t6_state", S_STATE, 2); push("t6_win", S_WIN, 1);
        push("t6_wv", S_WV, 1);       push("t6_p2", S_P2, 3);
        push("t6_p3", S_P3, 0);
        drain();
        end_game();

        // enable_board falling in RUN aborts without result
        in_game = 4'b0011; enable_board = 1'b1;
        cyc();
        repeat (4) tick_cyc();
        enable_board = 1'b0;
        cyc();
        push("ab_state", S_STATE, 0); push("ab_wv", S_WV, 0);
        push("ab_tie", S_TIE, 0);     push("ab_p1", S_P1, 4);
        drain();

        // Test 3: solo game, 500 ticks then death; OVER ignores further ticks
        in_game = 4'b0100; enable_board = 1'b1;
        cyc();
        repeat (500) tick_cyc();
        dead = 4'b0100;
        cyc();
        push("t3_state", S_STATE, 2); push("t3_p3", S_P3, 500);
        push("t3_wv", S_WV, 0);       push("t3_tie", S_TIE, 0);
        drain();
        repeat (20) tick_cyc();
        push("t3_p3_frz", S_P3, 500); push("t3_el_frz", S_EL, 500);
        drain();
        end_game();

        // Test 5: asynchronous reset mid-RUN
        in_game = 4'b1111; enable_board = 1'b1;
        cyc();
        repeat (40) tick_cyc();
        push("t5_pre_p1", S_P1, 40);
        drain();
        #2;
        reset = 1'b0;
        #1;
        push("t5_state", S_STATE, 0); push("t5_p1", S_P1, 0);
        push("t5_p4", S_P4, 0);       push("t5_el", S_EL, 0);
        push("t5_freeze", S_FREEZE, 0);
        drain();
        cyc();
        reset = 1'b1; in_game = 4'b0011;
        cyc();
        push("t5_rerun", S_STATE, 1); push("t5_rerun_p1", S_P1, 0);
        drain();
        repeat (2) tick_cyc();
        push("t5_p1_2", S_P1, 2); push("t5_el_2", S_EL, 2);
        drain();
        enable_board = 1'b0;
        cyc();

        // Test 4: counter saturation on the narrow instance
        s_in_game = 4'b0001; s_en = 1'b1;
        cyc();
        s_tick = 1'b1;
        repeat (SAT_MAX - 1) cyc();
        push("t4_pre_p1", S_SP1, sat_exp(SAT_MAX - 1));
        push("t4_pre_el", S_SEL, sat_exp(SAT_MAX - 1));
        drain();
        repeat (3) cyc();
        s_tick = 1'b0;
        push("t4_sat_p1", S_SP1, sat_exp(SAT_MAX));
        push("t4_sat_el", S_SEL, sat_exp(SAT_MAX));
        push("t4_misc", S_SMISC, 32'b01_0_00_0_0 << 0);
        push("t4_others", S_SOTH, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
